// File: rtl/fifo_port_scheduler_pkg.sv
// Shared types and default sizing for the FIFO port scheduler.
// Defaults describe a 4-requester, 8-bit, 8-deep FIFO with bursts of two.
package fifo_sched_pkg;
    localparam int NREQ_DEF  = 4;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 8;
    localparam int BURST_DEF = 2;
    localparam int LVL_W     = $clog2(DEPTH_DEF + 1);
    localparam int ID_W      = $clog2(NREQ_DEF);

    typedef enum logic {SLOT_READ, SLOT_WRITE} slot_e;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/fifo_port_scheduler_if.sv
// Bundle of requester, reader and FIFO-side signals for the port scheduler.
// Handshake: a requester word transfers on a rising edge where req_valid[i] & req_ready[i];
// req_ready is combinational and at most one bit is high; rd_req is a level, rd_ack marks issue.
interface fifo_port_scheduler_if
    import fifo_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rd_req;
    logic               rd_ack;
    logic               rd_valid;
    logic               fifo_wn;
    logic               fifo_rn;
    logic [DW-1:0]      fifo_din;
    logic [LW-1:0]      level;
    logic               full;
    logic               empty;
    logic [IW-1:0]      owner;
    arb_state_e         state;

    modport master (
        output req_valid, req_data, rd_req,
        input  req_ready, rd_ack, rd_valid, fifo_wn, fifo_rn, fifo_din,
        input  level, full, empty, owner, state
    );

    modport slave (
        input  req_valid, req_data, rd_req,
        output req_ready, rd_ack, rd_valid, fifo_wn, fifo_rn, fifo_din,
        output level, full, empty, owner, state
    );
endinterface

// File: rtl/fifo_port_scheduler_rr_arbiter.sv
// Round-robin requester picker: a locked owner wins while it stays valid,
// otherwise the first valid requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    input  logic [IW-1:0]   lock_id,
    input  logic            lock_en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_id
);
    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        if (lock_en && req[lock_id]) begin
            grant[lock_id] = 1'b1;
            grant_id       = lock_id;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = IW'(idx);
                end
            end
        end
    end
endmodule

// File: rtl/fifo_port_scheduler.sv
// Arbitrates NREQ writers and one reader onto a single-op-per-cycle FIFO,
// keeping the authoritative occupancy so the FIFO is never over- or under-run.
module fifo_port_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int BURST = BURST_DEF
) (
    input logic                  clock,
    input logic                  reset_n,
    fifo_port_scheduler_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(BURST + 1);

    logic [LW-1:0]   level_q;
    slot_e           last_slot;
    arb_state_e      state_q;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner_q;
    logic [BW-1:0]   burst_cnt;
    logic            wn_q, rn_q, ack_q, rvalid_q;
    logic [DW-1:0]   din_q;

    logic            full_w, empty_w, can_wr, can_rd, do_wr, do_rd;
    logic            lock_en, lock_hit;
    logic [IW-1:0]   ptr_eff, grant_id;
    logic [NREQ-1:0] grant;

    assign full_w  = (level_q == LW'(DEPTH));
    assign empty_w = (level_q == '0);
    // reset_n gates the write side so no requester sees ready while held in reset
    assign can_wr  = reset_n && (|bus.req_valid) && !full_w;
    assign can_rd  = bus.rd_req && !empty_w;
    assign do_wr   = can_wr && (!can_rd || last_slot == SLOT_READ);
    assign do_rd   = can_rd && !do_wr;

    assign lock_en  = (state_q == LOCKED) && (burst_cnt < BW'(BURST));
    assign lock_hit = lock_en && bus.req_valid[owner_q];
    // Leaving a lock restarts the search just past the owner, in the same cycle
    assign ptr_eff  = (state_q != LOCKED)        ? rr_ptr :
                      (owner_q == IW'(NREQ - 1)) ? '0     : owner_q + IW'(1);

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req      (bus.req_valid),
        .rr_ptr   (ptr_eff),
        .lock_id  (owner_q),
        .lock_en  (lock_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q   <= '0;
            last_slot <= SLOT_READ;
            state_q   <= IDLE;
            rr_ptr    <= '0;
            owner_q   <= '0;
            burst_cnt <= '0;
            wn_q      <= 1'b0;
            rn_q      <= 1'b0;
            ack_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            din_q     <= '0;
        end else begin
            wn_q     <= do_wr;
            rn_q     <= do_rd;
            ack_q    <= do_rd;
            rvalid_q <= rn_q;
            if (do_wr) begin
                din_q     <= bus.req_data[int'(grant_id)*DW +: DW];
                level_q   <= level_q + LW'(1);
                last_slot <= SLOT_WRITE;
                if (lock_hit) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end else begin
                    state_q   <= LOCKED;
                    owner_q   <= grant_id;
                    burst_cnt <= BW'(1);
                    rr_ptr    <= ptr_eff;
                end
            end else if (do_rd) begin
                level_q   <= level_q - LW'(1);
                last_slot <= SLOT_READ;
            end
        end
    end

    assign bus.req_ready = do_wr ? grant : '0;
    assign bus.fifo_wn   = wn_q;
    assign bus.fifo_rn   = rn_q;
    assign bus.rd_ack    = ack_q;
    assign bus.rd_valid  = rvalid_q;
    assign bus.fifo_din  = din_q;
    assign bus.level     = level_q;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.owner     = owner_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Bench for fifo_port_scheduler: a rule-level model checked every cycle, a small FIFO
// driven by the scheduler's outputs, and directed scenarios with literal expectations.
module tb_fifo_port_scheduler;
    import fifo_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int BURST = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fifo_port_scheduler_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) bus_if ();

    fifo_port_scheduler #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The FIFO being scheduled, driven only by the DUT's wn/rn/din
    logic [DW-1:0] mem [DEPTH];
    int            wp, rp;
    logic [DW-1:0] dataout;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp = 0; rp = 0; dataout = '0;
        end else begin
            if (bus_if.fifo_wn) begin
                mem[wp] = bus_if.fifo_din;
                wp = (wp + 1) % DEPTH;
            end
            if (bus_if.fifo_rn) begin
                dataout = mem[rp];
                rp = (rp + 1) % DEPTH;
            end
        end
    end

    // Behavioural model state
    int            m_level, m_owner, m_cnt, m_ptr;
    bit            m_locked, m_last_wr;
    bit            m_wn, m_rn, m_ack, m_rvalid;
    logic [DW-1:0] m_din, m_rd_stage, m_rd_data;
    logic [DW-1:0] exp_q[$];
    int            m_grants[$];
    int            d_grants[$];

    // slot: 0 idle, 1 write, 2 read
    task automatic model_pick(output int slot, output int win, output bit cont, output int start);
        bit cw, cr;
        cw = (bus_if.req_valid != 0) && (m_level < DEPTH);
        cr = bus_if.rd_req && (m_level > 0);
        slot = 0;
        if (cw && cr) slot = m_last_wr ? 2 : 1;
        else if (cw) slot = 1;
        else if (cr) slot = 2;
        cont  = m_locked && bus_if.req_valid[m_owner] && (m_cnt < BURST);
        start = m_locked ? (m_owner + 1) % NREQ : m_ptr;
        win = -1;
        if (cont) win = m_owner;
        else
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && bus_if.req_valid[(start + k) % NREQ]) win = (start + k) % NREQ;
    endtask

    always @(posedge clock or negedge reset_n) begin : model_upd
        int slot, win, start;
        bit cont;
        if (!reset_n) begin
            m_level = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
            m_locked = 0; m_last_wr = 0;
            m_wn = 0; m_rn = 0; m_ack = 0; m_rvalid = 0;
            m_din = '0; m_rd_stage = '0; m_rd_data = '0;
            exp_q.delete();
        end else begin
            model_pick(slot, win, cont, start);
            m_rvalid  = m_rn;
            m_rd_data = m_rd_stage;
            m_wn  = (slot == 1);
            m_rn  = (slot == 2);
            m_ack = m_rn;
            if (slot == 1) begin
                m_din = bus_if.req_data[win*DW +: DW];
                exp_q.push_back(m_din);
                m_grants.push_back(win);
                m_level++;
                m_last_wr = 1;
                if (cont) m_cnt++;
                else begin
                    m_locked = 1; m_owner = win; m_cnt = 1; m_ptr = start;
                end
            end else if (slot == 2) begin
                m_rd_stage = exp_q.pop_front();
                m_level--;
                m_last_wr = 0;
            end
        end
    end

    always @(negedge clock) begin : compare
        int slot, win, start;
        bit cont;
        logic [NREQ-1:0] exp_ready;
        if (reset_n) begin
            model_pick(slot, win, cont, start);
            exp_ready = (slot == 1) ? NREQ'(1 << win) : '0;
            check("req_ready", 32'(bus_if.req_ready), 32'(exp_ready));
            check("fifo_wn", 32'(bus_if.fifo_wn), 32'(m_wn));
            check("fifo_rn", 32'(bus_if.fifo_rn), 32'(m_rn));
            check("wn_rn_exclusive", 32'(bus_if.fifo_wn & bus_if.fifo_rn), 32'd0);
            check("rd_ack", 32'(bus_if.rd_ack), 32'(m_ack));
            check("rd_valid", 32'(bus_if.rd_valid), 32'(m_rvalid));
            check("level", 32'(bus_if.level), 32'(m_level));
            check("full", 32'(bus_if.full), 32'(m_level == DEPTH));
            check("empty", 32'(bus_if.empty), 32'(m_level == 0));
            check("owner", 32'(bus_if.owner), 32'(m_owner));
            if (m_wn) check("fifo_din", 32'(bus_if.fifo_din), 32'(m_din));
            if (m_rvalid) check("dataout", 32'(dataout), 32'(m_rd_data));
            for (int i = 0; i < NREQ; i++)
                if (bus_if.req_ready[i]) d_grants.push_back(i);
        end
    end

    function automatic logic [NREQ*DW-1:0] mk_data(input int seq);
        logic [NREQ*DW-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i*DW +: DW] = DW'((i << 4) | (seq & 15));
        return r;
    endfunction

    // Inputs are applied just after a rising edge, then held for n cycles
    task automatic step(input logic [NREQ-1:0] v, input logic rd, input logic [NREQ*DW-1:0] d,
                        input int n);
        bus_if.req_valid = v;
        bus_if.rd_req    = rd;
        bus_if.req_data  = d;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, 32'(bus_if.level), 32'd0);
        check({tag, "_empty"}, 32'(bus_if.empty), 32'd1);
        check({tag, "_full"}, 32'(bus_if.full), 32'd0);
        check({tag, "_wn"}, 32'(bus_if.fifo_wn), 32'd0);
        check({tag, "_rn"}, 32'(bus_if.fifo_rn), 32'd0);
        check({tag, "_ack"}, 32'(bus_if.rd_ack), 32'd0);
        check({tag, "_ready"}, 32'(bus_if.req_ready), 32'd0);
        check({tag, "_owner"}, 32'(bus_if.owner), 32'd0);
        check({tag, "_state"}, 32'(bus_if.state), 32'(IDLE));
    endtask

    int exp_t2[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int exp_t3[4] = '{0, 0, 1, 1};
    logic [NREQ*DW-1:0] d_a5;
    logic [NREQ-1:0]    mix_v[6] = '{4'b0011, 4'b1010, 4'b0110, 4'b1111, 4'b0001, 4'b1001};

    initial begin
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.rd_req    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // All writers valid, no reads: bursts of two in rotation until full
        d_grants.delete(); m_grants.delete();
        step(4'hF, 1'b0, mk_data(1), 10);
        check("t2_level", 32'(bus_if.level), 32'd8);
        check("t2_full", 32'(bus_if.full), 32'd1);
        check("t2_ready_full", 32'(bus_if.req_ready), 32'd0);
        check("t2_dut_count", 32'(d_grants.size()), 32'd8);
        check("t2_model_count", 32'(m_grants.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check("t2_dut_grant", 32'((d_grants.size() > k) ? d_grants[k] : 99), 32'(exp_t2[k]));
            check("t2_model_grant", 32'((m_grants.size() > k) ? m_grants[k] : 99), 32'(exp_t2[k]));
        end

        // Full with reader active: strict alternation, level between 7 and 8
        d_grants.delete();
        for (int k = 0; k < 8; k++) begin
            step(4'hF, 1'b1, mk_data(2 + k), 1);
            check("t3_level_osc", 32'((bus_if.level == 7) || (bus_if.level == 8)), 32'd1);
            check("t3_wn_alt", 32'(bus_if.fifo_wn), 32'(k % 2));
        end
        check("t3_level_end", 32'(bus_if.level), 32'd8);
        for (int k = 0; k < 4; k++)
            check("t3_dut_grant", 32'((d_grants.size() > k) ? d_grants[k] : 99), 32'(exp_t3[k]));

        // Drain, then reader alone on an empty FIFO
        step('0, 1'b1, '0, 12);
        check("drain_empty", 32'(bus_if.empty), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step('0, 1'b1, '0, 1);
            check("t6_rd_ack", 32'(bus_if.rd_ack), 32'd0);
            check("t6_level", 32'(bus_if.level), 32'd0);
        end

        // Single word 0xA5 from requester 2, read back
        d_a5 = mk_data(0);
        d_a5[2*DW +: DW] = 8'hA5;
        step(4'b0100, 1'b0, d_a5, 1);
        check("t4_wn", 32'(bus_if.fifo_wn), 32'd1);
        check("t4_din", 32'(bus_if.fifo_din), 32'hA5);
        check("t4_level1", 32'(bus_if.level), 32'd1);
        step('0, 1'b1, '0, 1);
        check("t4_rn", 32'(bus_if.fifo_rn), 32'd1);
        check("t4_ack", 32'(bus_if.rd_ack), 32'd1);
        step('0, 1'b0, '0, 1);
        check("t4_rd_valid", 32'(bus_if.rd_valid), 32'd1);
        check("t4_dataout", 32'(dataout), 32'hA5);
        check("t4_level0", 32'(bus_if.level), 32'd0);

        // Owner 3 drops after one grant; requester 0 follows with no bubble
        bus_if.req_valid = 4'b1000;
        bus_if.req_data  = mk_data(5);
        #1;
        check("t5_ready_3", 32'(bus_if.req_ready), 32'b1000);
        @(posedge clock);
        #1;
        bus_if.req_valid = 4'b0001;
        #1;
        check("t5_ready_0", 32'(bus_if.req_ready), 32'b0001);
        @(posedge clock);
        #1;
        check("t5_wn", 32'(bus_if.fifo_wn), 32'd1);
        check("t5_owner", 32'(bus_if.owner), 32'd0);
        check("t5_din", 32'(bus_if.fifo_din), 32'h05);

        // Mixed writer patterns with an intermittent reader
        for (int i = 0; i < 12; i++)
            step(mix_v[i % 6], 1'((i % 3) != 0), mk_data(10 + i), 2);

        // Reset in the middle of a burst at level 5
        step('0, 1'b1, '0, 12);
        step(4'hF, 1'b0, mk_data(7), 5);
        check("t1_level5", 32'(bus_if.level), 32'd5);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t1");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(4'hF, 1'b0, mk_data(8), 4);
        check("t1_post_level", 32'(bus_if.level), 32'd4);
        check("t1_post_owner", 32'(bus_if.owner), 32'd1);

        step('0, 1'b0, '0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
